// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the program loader.
package prog_loader_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int NUM_WORDS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/prog_loader_edge_detector.sv
// Registered-previous-value edge detector; the previous value tracks the input
// even during reset so a level held across reset release is not seen as an edge.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    output logic rising_edge_o,
    output logic falling_edge_o
);

    logic prev;

    always_ff @(posedge clk) begin
        prev <= a_i;
    end

    assign rising_edge_o  = !rst && a_i && !prev;
    assign falling_edge_o = !rst && !a_i && prev;

endmodule

// File: rtl/prog_loader.sv
// Streams a 16-byte image plus checksum byte into the program RAM and keeps the
// CPU halted until the image is verified.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output state_t            state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic              start_rise;
    logic              unused_start_fall;
    logic              hs;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] check_total;

    edge_detector u_start_edge (
        .clk           (clk),
        .rst           (rst),
        .a_i           (start),
        .rising_edge_o (start_rise),
        .falling_edge_o(unused_start_fall)
    );

    // Handshake view is built only from the registered state plus in_valid.
    assign hs          = in_valid && in_ready;
    assign check_total = sum + in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            sum       <= '0;
            prog_mode <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            prog_mode <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= LOAD;
                        addr  <= '0;
                        sum   <= '0;
                    end
                end
                LOAD: begin
                    // A restart wins over a same-cycle handshake, which is dropped.
                    if (start_rise) begin
                        addr <= '0;
                        sum  <= '0;
                    end else if (hs) begin
                        sum       <= sum + in_data;
                        prog_addr <= addr;
                        prog_data <= in_data;
                        prog_mode <= 1'b1;
                        addr      <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (start_rise) begin
                        state <= LOAD;
                        addr  <= '0;
                        sum   <= '0;
                    end else if (hs) begin
                        state <= (check_total == '0) ? DONE : ERROR;
                    end
                end
                DONE, ERROR: begin
                    if (start_rise) begin
                        state <= LOAD;
                        addr  <= '0;
                        sum   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == LOAD) || (state == CHECK);
    assign busy     = (state == LOAD) || (state == CHECK);
    assign cpu_halt = (state == LOAD) || (state == CHECK) || (state == ERROR);
    assign done     = (state == DONE);
    assign err      = (state == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full loads, bad checksum, bubbles, restart,
// mid-load reset and start held across reset.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prog_mode;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       err;
    state_t     state;

    int total;
    int bad;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prog_mode(prog_mode),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one LOAD-phase byte and checks the write pulse that follows it.
    task automatic send_byte(input logic [7:0] d, input logic [3:0] exp_addr);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        check("pulse", 32'(prog_mode), 32'd1);
        check("addr", 32'(prog_addr), 32'(exp_addr));
        check("data", 32'(prog_data), 32'(d));
    endtask

    task automatic toggle_start();
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    initial begin
        int acc;
        int pulses;
        int cycles;
        logic v;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_halt", 32'(cpu_halt), 32'd0);
        check("rst_mode", 32'(prog_mode), 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);

        // Image 0x01..0x10, good checksum 0x78.
        start = 1'b1;
        tick();
        check("load_state", 32'(state), 32'(LOAD));
        check("load_busy", 32'(busy), 32'd1);
        check("load_halt", 32'(cpu_halt), 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 4'(i));
        check("check_state", 32'(state), 32'(CHECK));
        in_data = 8'h78;
        tick();
        in_valid = 1'b0;
        check("good_done", 32'(done), 32'd1);
        check("good_halt", 32'(cpu_halt), 32'd0);
        check("good_err", 32'(err), 32'd0);
        check("good_ready", 32'(in_ready), 32'd0);
        check("ck_no_pulse", 32'(prog_mode), 32'd0);

        // Same image, bad checksum 0x77.
        toggle_start();
        check("reload_done", 32'(done), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 4'(i));
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        check("bad_err", 32'(err), 32'd1);
        check("bad_halt", 32'(cpu_halt), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        start = 1'b0;
        tick();
        check("err_hold", 32'(err), 32'd1);
        start = 1'b1;
        tick();
        check("err_clear", 32'(err), 32'd0);
        check("err_busy", 32'(busy), 32'd1);

        // 16x 0xFF with random bubbles, checksum 0x10.
        acc    = 0;
        pulses = 0;
        cycles = 0;
        while (acc < 17 && cycles < 300) begin
            v        = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = (acc < 16) ? 8'hFF : 8'h10;
            tick();
            cycles++;
            if (prog_mode) pulses++;
            if (v && acc < 16) begin
                check("bub_pulse", 32'(prog_mode), 32'd1);
                check("bub_addr", 32'(prog_addr), acc);
            end else begin
                check("bub_idle", 32'(prog_mode), 32'd0);
            end
            if (v) acc++;
        end
        in_valid = 1'b0;
        if (acc < 17) begin
            total++;
            bad++;
            $error("FAIL bub_timeout observed=%0d expected=17", acc);
        end
        check("bub_pulses", pulses, 32'd16);
        check("bub_done", 32'(done), 32'd1);

        // Restart after 5 bytes; handshake in the restart cycle is dropped.
        toggle_start();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 4'(i));
        start = 1'b0;
        send_byte(8'h15, 4'd4);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        check("rs_no_pulse", 32'(prog_mode), 32'd0);
        check("rs_hold_addr", 32'(prog_addr), 32'd4);
        check("rs_hold_data", 32'(prog_data), 32'h15);
        check("rs_state", 32'(state), 32'(LOAD));
        send_byte(8'hAA, 4'd0);
        for (int i = 1; i < 16; i++) send_byte(8'h01, 4'(i));
        in_data = 8'h47;
        tick();
        in_valid = 1'b0;
        check("rs_done", 32'(done), 32'd1);

        // Reset after 7 bytes, start held high across release.
        toggle_start();
        for (int i = 0; i < 7; i++) send_byte(8'(8'h20 + i), 4'(i));
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mr_state", 32'(state), 32'(IDLE));
        check("mr_outs", {in_ready, prog_mode, cpu_halt, busy, done, err}, 32'd0);
        check("mr_addr", 32'(prog_addr), 32'd0);
        check("mr_data", 32'(prog_data), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_state", 32'(state), 32'(IDLE));
            check("idle_ready", 32'(in_ready), 32'd0);
            check("idle_mode", 32'(prog_mode), 32'd0);
        end
        in_valid = 1'b0;

        toggle_start();
        check("tg_state", 32'(state), 32'(LOAD));
        check("tg_busy", 32'(busy), 32'd1);
        send_byte(8'h33, 4'd0);
        in_valid = 1'b0;
        tick();
        check("tg_single", 32'(prog_mode), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
